// File: rtl/alarm_pkg.sv
// Shared alarm-clock definitions: ring-sequencer states and digit constants.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOCKOUT = 3'd1,
        ARMED   = 3'd2,
        RINGING = 3'd3,
        SNOOZE  = 3'd4
    } state_e;

    // Width of one BCD digit.
    localparam int unsigned DIGIT_W = 4;

    // Keypad "no key pressed" code, shared with the keypad logic.
    localparam int unsigned NO_KEY = 10;

endpackage

// File: rtl/alarm_time_match.sv
// Combinational HH:MM BCD comparator; also used by the display-blink logic.
module alarm_time_match
    import alarm_pkg::*;
(
    input  logic [DIGIT_W-1:0] cur_ms_hour_i,
    input  logic [DIGIT_W-1:0] cur_ls_hour_i,
    input  logic [DIGIT_W-1:0] cur_ms_min_i,
    input  logic [DIGIT_W-1:0] cur_ls_min_i,
    input  logic [DIGIT_W-1:0] alm_ms_hour_i,
    input  logic [DIGIT_W-1:0] alm_ls_hour_i,
    input  logic [DIGIT_W-1:0] alm_ms_min_i,
    input  logic [DIGIT_W-1:0] alm_ls_min_i,
    output logic               match_o
);

    // All four digits must agree.
    always_comb begin
        match_o = ({cur_ms_hour_i, cur_ls_hour_i, cur_ms_min_i, cur_ls_min_i} ==
                   {alm_ms_hour_i, alm_ls_hour_i, alm_ms_min_i, alm_ls_min_i});
    end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: arms on time mismatch, rings on match, handles
// snooze, stop and ring timeout.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter int unsigned SNOOZE_MIN  = 5,
    parameter int unsigned SNOOZE_MAX  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               one_second,
    input  logic               one_minute,
    input  logic [DIGIT_W-1:0] cur_ms_hour,
    input  logic [DIGIT_W-1:0] cur_ls_hour,
    input  logic [DIGIT_W-1:0] cur_ms_min,
    input  logic [DIGIT_W-1:0] cur_ls_min,
    input  logic [DIGIT_W-1:0] alm_ms_hour,
    input  logic [DIGIT_W-1:0] alm_ls_hour,
    input  logic [DIGIT_W-1:0] alm_ms_min,
    input  logic [DIGIT_W-1:0] alm_ls_min,
    input  logic               alarm_enable,
    input  logic               snooze_button,
    input  logic               stop_button,
    output logic               alarm_sound,
    output logic               snooze_active,
    output logic [1:0]         snooze_count
);

    localparam logic [5:0] SEC_LIMIT = 6'(TIMEOUT_SEC);
    localparam logic [3:0] MIN_LIMIT = 4'(SNOOZE_MIN);
    localparam logic [1:0] SNZ_LIMIT = 2'(SNOOZE_MAX);

    state_e     state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [3:0] min_q, min_d;
    logic [1:0] snz_q, snz_d;
    logic       match;
    logic [5:0] sec_inc;
    logic [3:0] min_inc;

    alarm_time_match u_match (
        .cur_ms_hour_i (cur_ms_hour),
        .cur_ls_hour_i (cur_ls_hour),
        .cur_ms_min_i  (cur_ms_min),
        .cur_ls_min_i  (cur_ls_min),
        .alm_ms_hour_i (alm_ms_hour),
        .alm_ls_hour_i (alm_ls_hour),
        .alm_ms_min_i  (alm_ms_min),
        .alm_ls_min_i  (alm_ls_min),
        .match_o       (match)
    );

    // Saturating increments so the counters can never wrap.
    always_comb begin
        sec_inc = (sec_q == '1) ? sec_q : sec_q + 6'd1;
        min_inc = (min_q == '1) ? min_q : min_q + 4'd1;
    end

    // Next-state and counter update, in priority order:
    // disable > stop > snooze > strobes.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        snz_d   = snz_q;
        if (!alarm_enable) begin
            state_d = IDLE;
            sec_d   = '0;
            min_d   = '0;
            snz_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = LOCKOUT;
                end
                LOCKOUT: begin
                    if (!match) state_d = ARMED;
                end
                ARMED: begin
                    if (match) begin
                        state_d = RINGING;
                        sec_d   = '0;
                        snz_d   = '0;
                    end
                end
                RINGING: begin
                    if (stop_button) begin
                        state_d = LOCKOUT;
                        sec_d   = '0;
                        min_d   = '0;
                    end else if (snooze_button) begin
                        if (snz_q < SNZ_LIMIT) begin
                            state_d = SNOOZE;
                            snz_d   = snz_q + 2'd1;
                            min_d   = '0;
                        end else begin
                            state_d = LOCKOUT;
                            sec_d   = '0;
                            min_d   = '0;
                        end
                    end else if (one_second) begin
                        if (sec_inc >= SEC_LIMIT) begin
                            state_d = LOCKOUT;
                            sec_d   = '0;
                            min_d   = '0;
                        end else begin
                            sec_d = sec_inc;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_button) begin
                        state_d = LOCKOUT;
                        sec_d   = '0;
                        min_d   = '0;
                    end else if (one_minute) begin
                        if (min_inc >= MIN_LIMIT) begin
                            state_d = RINGING;
                            sec_d   = '0;
                            min_d   = '0;
                        end else begin
                            min_d = min_inc;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    sec_d   = '0;
                    min_d   = '0;
                    snz_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sec_q   <= '0;
            min_q   <= '0;
            snz_q   <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            snz_q   <= snz_d;
        end
    end

    // Outputs decode only registered state, so buttons never reach them combinationally.
    always_comb begin
        alarm_sound   = (state_q == RINGING);
        snooze_active = (state_q == SNOOZE);
        snooze_count  = snz_q;
    end

endmodule
